// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped TX/RX FIFO sequencer for the uart, with sticky RX overflow and irq
module uart_mmio_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic        irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  logic          r_ov, r_irq, r_rx_rdy;
  logic [31:0]   r_rdata;

  logic          w_hit, w_flush, w_clr, w_tx_full, w_rx_full, w_rx_ne;
  logic          w_tx_pop, w_tx_push, w_rx_pop, w_rx_in, w_rx_push, w_ovf, w_unused;
  logic [3:0]    w_off;
  logic [31:0]   w_status, w_rd;

  assign w_hit     = addr[31:4] == BASE_ADDR[31:4];
  assign w_off     = addr[3:0];
  assign w_flush   = we & w_hit & (w_off == 4'hC) & wdata[1];
  assign w_clr     = we & w_hit & (w_off == 4'hC) & wdata[0];
  assign w_tx_full = r_tx_cnt == CW'(FIFO_DEPTH);
  assign w_rx_full = r_rx_cnt == CW'(FIFO_DEPTH);
  assign w_rx_ne   = r_rx_cnt != '0;
  assign w_unused  = &{1'b0, wdata[31:8]};

  // A flush wins over every same-cycle push and pop; a pop frees a slot for a same-cycle push.
  assign w_tx_pop  = uart_tx_valid & uart_tx_ready & ~w_flush;
  assign w_tx_push = we & w_hit & (w_off == 4'h8) & (~w_tx_full | w_tx_pop) & ~w_flush;
  assign w_rx_pop  = re & w_hit & (w_off == 4'h4) & w_rx_ne & ~w_flush;
  assign w_rx_in   = uart_rx_valid & r_rx_rdy & ~w_flush;
  assign w_rx_push = w_rx_in & (~w_rx_full | w_rx_pop);
  assign w_ovf     = w_rx_in & w_rx_full & ~w_rx_pop;

  assign w_status = {8'd0, 8'(r_tx_cnt), 8'(r_rx_cnt), 5'd0, r_ov, w_rx_ne, ~w_tx_full};
  assign w_rd     = ~w_hit                          ? 32'd0 :
                    w_off == 4'h0                   ? w_status :
                    (w_off == 4'h4) & w_rx_ne       ? {24'd0, r_rx_mem[r_rx_rp]} : 32'd0;

  assign rdata         = r_rdata;
  assign irq           = r_irq;
  assign uart_rx_ready = r_rx_rdy;
  assign uart_tx_valid = r_tx_cnt != '0;
  assign uart_tx_data  = r_tx_mem[r_tx_rp];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= uart_rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
      r_ov     <= 1'b0;
      r_irq    <= 1'b0;
      r_rx_rdy <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_tx_wp  <= w_flush ? '0 : r_tx_wp + PW'(w_tx_push);
      r_tx_rp  <= w_flush ? '0 : r_tx_rp + PW'(w_tx_pop);
      r_rx_wp  <= w_flush ? '0 : r_rx_wp + PW'(w_rx_push);
      r_rx_rp  <= w_flush ? '0 : r_rx_rp + PW'(w_rx_pop);
      r_tx_cnt <= w_flush ? '0 : r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      r_rx_cnt <= w_flush ? '0 : r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
      r_ov     <= w_ovf ? 1'b1 : w_clr ? 1'b0 : r_ov;
      r_irq    <= w_rx_ne | r_ov;
      r_rx_rdy <= 1'b1;
      if (re) r_rdata <= w_rd;
    end
  end
endmodule
